// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
// Provides datapath widths, the PC increment, the default reset PC, the
// buffered entry type {pc, instr} and a word-alignment helper.
package rv_fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   push, wr_data    - write an entry (ignored when full)
//   pop, rd_data     - remove the head entry (ignored when empty); rd_data is the head
//   flush            - empty the FIFO; wins over push and pop
//   full, empty      - occupancy flags
//   count            - number of stored entries
module instr_fifo
    import rv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_data,
    output fetch_entry_t               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush && !reset) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, issues word reads to
// instruction memory under a credit limit, buffers returned words with
// their PCs and hands them to decode. Redirects flush the buffer and
// discard responses still in flight.
// Ports:
//   clk, reset                     - rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready/addr      - memory read request channel
//   imem_rsp_valid/data            - in-order read responses, always accepted
//   redirect_valid, redirect_pc    - one-cycle redirect from execute
//   instr_valid/ready              - decode handshake
//   instruction, instr_pc          - head-of-buffer word and its PC (0 when empty)
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_wr;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_accept;

    // Outstanding requests plus buffered entries never exceed DEPTH, so a
    // response always finds room in the buffer.
    assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_accept = imem_rsp_valid && !redirect_valid && (drop == '0);
    assign fifo_push  = rsp_accept && !fifo_full;
    assign fifo_wr    = '{pc: rsp_pc, instr: imem_rsp_data};

    assign instr_valid = !reset && !fifo_empty && !redirect_valid;
    assign fifo_pop    = instr_valid && instr_ready;
    assign instruction = fifo_empty ? '0 : fifo_head.instr;
    assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= align_pc(RESET_PC);
            rsp_pc      <= align_pc(RESET_PC);
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= align_pc(redirect_pc);
            rsp_pc      <= align_pc(redirect_pc);
            // A response landing in the redirect cycle is discarded here,
            // so it no longer needs to be counted as stale.
            drop        <= outstanding - CW'(imem_rsp_valid);
            outstanding <= outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_INC;
            if (imem_rsp_valid) begin
                if (drop != '0) drop <= drop - 1'b1;
                else            rsp_pc <= rsp_pc + PC_INC;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (redirect_valid),
        .wr_data (fifo_wr),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule
